// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with bypass, busy scoreboard
// and a handshaked debug dump sequencer.
module reg_file_sb #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter bit BYPASS   = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Clear,
    input  logic              LD_REG,
    input  logic [ADDR_W-1:0] DR,
    input  logic [DATA_W-1:0] DIN,
    input  logic [ADDR_W-1:0] SR1,
    input  logic [ADDR_W-1:0] SR2,
    output logic [DATA_W-1:0] SR1OUT,
    output logic [DATA_W-1:0] SR2OUT,
    input  logic              Issue,
    input  logic [ADDR_W-1:0] Issue_DR,
    output logic              SR1_Busy,
    output logic              SR2_Busy,
    input  logic              Dump_Start,
    input  logic              Dump_Ready,
    output logic              Dump_Valid,
    output logic [ADDR_W-1:0] Dump_Idx,
    output logic [DATA_W-1:0] Dump_Data,
    output logic              Dump_Done
);

    localparam logic [ADDR_W:0]   NREG = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              done_q, done_d;

    logic dr_ok, sr1_ok, sr2_ok, iss_ok;
    logic wr_en, hit1, hit2;

    assign dr_ok  = {1'b0, DR} < NREG;
    assign sr1_ok = {1'b0, SR1} < NREG;
    assign sr2_ok = {1'b0, SR2} < NREG;
    assign iss_ok = {1'b0, Issue_DR} < NREG;

    // An ignored (out-of-range) write is never forwarded.
    assign wr_en = LD_REG && dr_ok;
    assign hit1  = BYPASS && wr_en && (DR == SR1);
    assign hit2  = BYPASS && wr_en && (DR == SR2);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (Clear) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[DR] <= DIN;
        end
    end

    // Clear first, then set, so a same-index Issue wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) busy_d[DR] = 1'b0;
        if (Issue && iss_ok) busy_d[Issue_DR] = 1'b1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            busy_q <= '0;
        end else if (Clear) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        SR1OUT = '0;
        if (sr1_ok) SR1OUT = regs[SR1];
        if (hit1) SR1OUT = DIN;
        SR1_Busy = sr1_ok && busy_q[SR1] && !hit1;
    end

    always_comb begin
        SR2OUT = '0;
        if (sr2_ok) SR2OUT = regs[SR2];
        if (hit2) SR2OUT = DIN;
        SR2_Busy = sr2_ok && busy_q[SR2] && !hit2;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (Dump_Start) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                end
            end
            S_RUN: begin
                if (Dump_Ready) begin
                    if (idx_q == LAST) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else if (Clear) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign Dump_Valid = (state_q == S_RUN);
    assign Dump_Idx   = idx_q;
    assign Dump_Done  = done_q;
    assign Dump_Data  = Dump_Valid ? regs[idx_q] : '0;

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised, general-purpose register file for the datapath. It has one write port and two combinational read ports, with optional write-to-read bypass. It adds a per-register busy scoreboard and a handshaked debug dump sequencer that streams every register out one per cycle. It replaces the fixed 8×16 register file between the bus and the ALU/address path.

## Interface
- DATA_W, 16, register width in bits
- NUM_REGS, 8, number of registers (≥2; need not be a power of two)
- ADDR_W, $clog2(NUM_REGS), index width (derived; do not override)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports and busy outputs

Ports:
- Clk  in  1  single clock; all state updates on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Clear  in  1  synchronous clear of registers, scoreboard and dump FSM
- LD_REG  in  1  write enable
- DR  in  ADDR_W  write index
- DIN  in  DATA_W  write data
- SR1, SR2  in  ADDR_W  read indices
- SR1OUT, SR2OUT  out  DATA_W  read data
- Issue  in  1  mark Issue_DR busy
- Issue_DR  in  ADDR_W  scoreboard set index
- SR1_Busy, SR2_Busy  out  1  busy status of SR1/SR2
- Dump_Start  in  1  request a full dump
- Dump_Ready  in  1  consumer accepts the current dump word
- Dump_Valid  out  1  dump word present
- Dump_Idx  out  ADDR_W  index of the current dump word
- Dump_Data  out  DATA_W  contents of register Dump_Idx
- Dump_Done  out  1  one-cycle pulse after the last word is accepted

## Operation
- **Reset.** Reset_n low asynchronously clears all registers to 0 and all busy bits to 0. It forces the FSM to IDLE, with Dump_Idx=0 and Dump_Done=0. All outputs then read 0.
- **Clear.** Same effect as reset, taken at the clock edge. Clear has priority over LD_REG, Issue and the dump. An in-progress dump aborts without a Dump_Done pulse.
- **Write.** When LD_REG=1, R[DR] <= DIN. An out-of-range DR (≥NUM_REGS) is ignored.
- **Read.** SRxOUT = DIN when BYPASS=1, LD_REG=1 and DR==SRx; otherwise SRxOUT = R[SRx]. An out-of-range SRx reads 0.
- **Scoreboard set and clear.**
  - Issue=1 sets busy[Issue_DR].
  - LD_REG=1 clears busy[DR].
  - If both target the same index in one cycle, set wins and the bit stays 1.
  - Issue to an already-busy register leaves it busy.
  - Out-of-range indices are ignored.
- **Scoreboard read.** SRx_Busy = busy[SRx], masked to 0 when BYPASS=1, LD_REG=1 and DR==SRx. An out-of-range SRx returns 0.
- **Dump FSM, IDLE.** Dump_Valid=0 and Dump_Data=0. Dump_Start=1 moves to RUN with idx=0.
- **Dump FSM, RUN.**
  - Dump_Valid=1 and Dump_Idx=idx.
  - Dump_Data = R[idx], taken combinationally from the current register value with no bypass.
  - On Dump_Valid && Dump_Ready, idx increments.
  - If idx==NUM_REGS-1 at that handshake, the FSM returns to IDLE and Dump_Done pulses for one cycle.
  - Dump_Start is ignored in RUN.
  - Holding Dump_Ready low stalls with Dump_Idx and Dump_Valid stable. Dump_Data tracks writes to R[idx] during the stall.
- **Normal operation during a dump.** Writes, reads and the scoreboard run normally while dumping.

## Timing
- Read ports and busy outputs are combinational, with zero latency from SRx, R and bypass inputs.
- A write is visible on read ports the next cycle, or the same cycle through bypass.
- Scoreboard updates are visible the cycle after the edge, except for the bypass mask.
- Dump_Start sampled at edge N gives Dump_Valid=1 from cycle N+1.
- With Dump_Ready held at 1, words 0..NUM_REGS-1 appear on consecutive cycles N+1..N+NUM_REGS. Dump_Done=1 in cycle N+NUM_REGS+1 with Dump_Valid=0.
- A new Dump_Start is accepted in the same cycle that Dump_Done is high, since the FSM is already in IDLE.
- Reset_n asserted mid-dump takes effect immediately, without waiting for a clock edge.
- Deasserting Reset_n returns the block to normal operation at the next edge.

## Test plan
- **Reset.** Write 16'hBEEF to R3, then pulse Reset_n low mid-cycle. Required: SR1OUT with SR1=3 reads 0 before the next edge, and all busy outputs are 0.
- **Write and bypass.** With BYPASS=1, set LD_REG=1, DR=5, DIN=16'h1234, SR1=5, SR2=4. Required: SR1OUT=16'h1234 in the same cycle and SR2OUT=R4. With BYPASS=0, SR1OUT still shows the old value until the next cycle.
- **Scoreboard.** Issue R2 and read SR1=2 next cycle: SR1_Busy=1. Then LD_REG with DR=2: SR1_Busy=0 in the same cycle (bypass) and busy stays cleared afterward. Issue and LD_REG on R6 in the same cycle: R6 remains busy.
- **Dump at full rate.** Preload R0..R7 = 16'h0010..16'h0017 and hold Dump_Ready=1. Required: Dump_Idx 0..7 with matching data on 8 consecutive cycles, Dump_Done one cycle later, and a second Dump_Start during RUN is ignored.
- **Dump stall and abort.** Drop Dump_Ready at idx=3 for 4 cycles while writing R3=16'hAAAA. Required: Dump_Idx holds 3 and Dump_Data changes to 16'hAAAA. Then assert Clear: Dump_Valid=0 next cycle, no Dump_Done, and all registers are 0.
- **Non-power-of-two depth.** With NUM_REGS=6: a write to DR=7 is ignored, SR1=7 reads 0 with SR1_Busy=0, and the dump emits exactly 6 words.
